mmio_router: RTL
================

# mmio_router

Parametrised memory-mapped IO router between the CPU load/store port and up to `NUM_SLOTS` IO devices (LEDs, VRAM, SD card, PS/2, future slots). It decodes the device slot from the address, issues a one-cycle select to the device and waits for a per-slot acknowledge. It returns read data with byte-lane extraction and flags unmapped or unresponsive slots with a bus error. It replaces the fixed-latency, fixed-8-slot IO mux and carries the LED register bank internally as slot 0, now readable.

## Interface
- `NUM_SLOTS`, 8, number of decoded slots; power of two, 2..16
- `SEL_LSB`, 23, lowest address bit of the slot field; field width is `$clog2(NUM_SLOTS)`
- `DATA_W`, 16, bus data width; 16 or 32
- `DEV_ADDR_W`, 15, device-local address bits forwarded (`req_addr[DEV_ADDR_W-1:0]`)
- `SLOT_PRESENT`, 8'h0F, bit i set means slot i is populated
- `TIMEOUT`, 255, cycles to wait for `dev_ack` before a bus error; 1..65535
- `LED_COUNT`, 10, LED register bits in slot 0
- `main_clk  in  1  system clock`
- `main_rst_n  in  1  asynchronous active-low reset`
- `req_valid  in  1  CPU request`
- `req_ready  out  1  router idle, request accepted this cycle if valid`
- `req_addr  in  32  byte address; bit 31 must be 1 for IO`
- `req_wdata  in  DATA_W  write data`
- `req_write  in  1  1 = write, 0 = read`
- `req_byte  in  1  byte access`
- `rsp_valid  out  1  one-cycle response strobe`
- `rsp_rdata  out  DATA_W  read data, 0 on writes and errors`
- `rsp_err  out  1  bus error, valid with rsp_valid`
- `dev_sel  out  NUM_SLOTS  one-hot one-cycle select`
- `dev_write, dev_byte  out  1 each  registered request attributes`
- `dev_addr  out  DEV_ADDR_W  registered device-local address`
- `dev_wdata  out  DATA_W  registered write data, byte-replicated`
- `dev_rdata  in  NUM_SLOTS*DATA_W  slot i at bits [i*DATA_W +: DATA_W]`
- `dev_ack  in  NUM_SLOTS  completion from slot i`
- `led_out_state  out  LED_COUNT  LED register`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `req_ready`=1. On `req_valid`, latch the address, data and attributes, then go to ISSUE.
- **ISSUE:** decode the slot.
  - If `req_addr[31]`=0 or the slot is not present in `SLOT_PRESENT`, go straight to RESP with `rsp_err`=1 and no `dev_sel` pulse.
  - Otherwise pulse `dev_sel[slot]` for this cycle only, clear the timeout counter and go to WAIT.
- **WAIT:** the acknowledge for this state is sampled in the ISSUE cycle as well.
  - On `dev_ack[slot]`, capture that slot's `dev_rdata` and go to RESP with `rsp_err`=0.
  - When the counter reaches `TIMEOUT`, go to RESP with `rsp_err`=1 and `rdata`=0.
  - Acks from other slots, and any ack outside ISSUE/WAIT, are ignored.
- **RESP:** `rsp_valid`=1 for one cycle, then return to IDLE.
- **Write data:** `dev_wdata` = `req_byte` ? low byte replicated into every byte lane : `req_wdata`.
- **Read data:**
  - Byte reads return the lane chosen by `req_addr[$clog2(DATA_W/8)-1:0]`, zero-extended.
  - Word reads return the full word.
  - `rsp_rdata` is 0 for writes and for errors.
- **Slot 0 (LED bank):** handled internally.
  - The router generates its own ack in the cycle after ISSUE. External `dev_ack[0]` and the `dev_rdata` slot 0 bits are ignored.
  - Write to `dev_addr[3:0]` = n with n < `LED_COUNT` sets LED bit n to `wdata[0]`. Addresses with n ≥ `LED_COUNT` are ignored but still acked.
  - Read returns `{DATA_W-1 zeros, led[n]}`, or 0 if n is out of range.
- **Reset (asynchronous):** FSM to IDLE, all outputs 0 except `req_ready`=1. This includes `led_out_state`=0 and `dev_sel`=0, even mid-transaction. A transaction in flight at reset is dropped with no response.

## Timing
- Accept at cycle 0, `dev_sel` at cycle 1.
- Earliest response:
  - Ack in cycle 1: `rsp_valid` at cycle 2.
  - Slot 0: `rsp_valid` at cycle 3.
  - Error on an unmapped slot: `rsp_valid` at cycle 2.
- Timeout: ack absent through cycles 1..1+`TIMEOUT` gives `rsp_valid` and `rsp_err` at cycle 2+`TIMEOUT`.
- One transaction outstanding. Back-to-back issue: the next request is accepted in the cycle after RESP, so minimum period is 3 cycles.
- `dev_addr`, `dev_write`, `dev_byte` and `dev_wdata` hold stable from ISSUE through RESP.

## Structure
- Package `mmio_pkg`:
  - FSM state enum.
  - Slot index constants: `SLOT_LED`=0, `SLOT_VGA`=1, `SLOT_SD`=2, `SLOT_PS2`=3.
  - `IO_SPACE_BIT`=31.
- One sub-module, `mmio_led_bank`: LED register, internal ack and readback.

## Test plan
- Word write 16'h0001 to 0x8000_0003, then word read of the same address -> `led_out_state`[3]=1; read gives `rsp_rdata`=16'h0001, `rsp_err`=0, response 3 cycles after accept.
- Byte write 0xA5 to slot 1, address 0x0000_0801 -> `dev_sel`=8'h02 for exactly one cycle, `dev_wdata`=16'hA5A5, `dev_byte`=1, `dev_addr`=15'h0801.
- Byte read of slot 2, address 1, with `dev_rdata` slot 2 = 16'h12EF and ack in the ISSUE cycle -> `rsp_rdata`=16'h0012 at cycle 2.
- Access to slot 5, which is not present -> no `dev_sel` pulse, `rsp_err`=1 at cycle 2; with `req_addr[31]`=0 -> same result.
- `TIMEOUT`=4, slot 3 never acks -> `rsp_err`=1 and `rsp_rdata`=0 at cycle 6; an ack from slot 1 during WAIT is ignored.
- Assert `main_rst_n` low during WAIT -> `dev_sel`, `rsp_valid` and `led_out_state` are 0 immediately; `req_ready`=1; the next request completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-mapped IO router.
package mmio_pkg;

  // Router transaction states. Exactly one transaction is in flight at a time.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mmio_state_e;

  // Fixed slot assignments on the IO bus
  localparam int SLOT_LED = 0;
  localparam int SLOT_VGA = 1;
  localparam int SLOT_SD  = 2;
  localparam int SLOT_PS2 = 3;

  // Address bit that distinguishes IO space from memory space
  localparam int IO_SPACE_BIT = 31;

endpackage

// File: rtl/mmio_led_bank.sv
// LED register bank living in slot 0: write/readback of single LED bits and
// an internally generated acknowledge one cycle after the select.
module mmio_led_bank #(
  parameter int LED_COUNT = 10,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue,
  input  logic                 write,
  input  logic [3:0]           addr,
  input  logic                 wdata_bit,
  output logic                 ack,
  output logic [DATA_W-1:0]    rdata,
  output logic [LED_COUNT-1:0] led_state
);

  logic [LED_COUNT-1:0] led_q;
  logic                 ack_q;

  // LED bits update at the select; addresses beyond LED_COUNT are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= issue;
      for (int i = 0; i < LED_COUNT; i++) begin
        if (issue && write && (addr == 4'(i))) led_q[i] <= wdata_bit;
      end
    end
  end

  // Readback of the addressed LED bit, zero when out of range
  always_comb begin
    rdata = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (addr == 4'(i)) rdata[0] = led_q[i];
    end
  end

  assign ack       = ack_q;
  assign led_state = led_q;

endmodule

// File: rtl/mmio_router.sv
// Memory-mapped IO router: decodes a device slot from the CPU address, pulses
// a one-cycle select, waits for the slot's acknowledge (bounded by TIMEOUT)
// and returns lane-extracted read data or a bus error.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. rsp_valid is a
// one-cycle strobe with no back-pressure; rsp_err and rsp_rdata are only
// meaningful (and otherwise 0) while rsp_valid is high.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int                      NUM_SLOTS    = 8,
  parameter int                      SEL_LSB      = 23,
  parameter int                      DATA_W       = 16,
  parameter int                      DEV_ADDR_W   = 15,
  parameter logic [NUM_SLOTS-1:0]    SLOT_PRESENT = 8'h0F,
  parameter int                      TIMEOUT      = 255,
  parameter int                      LED_COUNT    = 10
) (
  input  logic                        main_clk,
  input  logic                        main_rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic                        req_write,
  input  logic                        req_byte,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [NUM_SLOTS-1:0]        dev_sel,
  output logic                        dev_write,
  output logic                        dev_byte,
  output logic [DEV_ADDR_W-1:0]       dev_addr,
  output logic [DATA_W-1:0]           dev_wdata,
  input  logic [NUM_SLOTS*DATA_W-1:0] dev_rdata,
  input  logic [NUM_SLOTS-1:0]        dev_ack,
  output logic [LED_COUNT-1:0]        led_out_state
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  mmio_state_e         state_q, state_d;
  logic [31:0]         addr_q;
  logic                write_q, byte_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [SLOT_W-1:0]   slot;
  logic                mapped;
  logic                slot_is_led;
  logic                led_issue;
  logic                led_ack;
  logic [DATA_W-1:0]   led_rdata;
  logic [DATA_W-1:0]   raw_rdata;
  logic [7:0]          lane_byte;
  logic [DATA_W-1:0]   read_val;
  logic                unused_addr;

  assign slot        = addr_q[SEL_LSB +: SLOT_W];
  assign mapped      = addr_q[IO_SPACE_BIT] && SLOT_PRESENT[slot];
  assign slot_is_led = (slot == SLOT_W'(SLOT_LED));
  assign led_issue   = (state_q == ST_ISSUE) && mapped && slot_is_led;
  assign unused_addr = ^addr_q;

  // Slot 0 data comes from the internal bank, never from the external bus
  assign raw_rdata = slot_is_led ? led_rdata : dev_rdata[int'(slot)*DATA_W +: DATA_W];
  assign lane_byte = 8'(raw_rdata >> {addr_q[LANE_W-1:0], 3'b000});
  assign read_val  = write_q ? '0 :
                     byte_q  ? {{(DATA_W-8){1'b0}}, lane_byte} : raw_rdata;

  mmio_led_bank #(
    .LED_COUNT (LED_COUNT),
    .DATA_W    (DATA_W)
  ) u_led_bank (
    .clk       (main_clk),
    .rst_n     (main_rst_n),
    .issue     (led_issue),
    .write     (write_q),
    .addr      (addr_q[3:0]),
    .wdata_bit (wdata_q[0]),
    .ack       (led_ack),
    .rdata     (led_rdata),
    .led_state (led_out_state)
  );

  // State register plus latched request attributes and response payload
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && req_valid) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        byte_q  <= req_byte;
        wdata_q <= req_byte ? {LANES{req_wdata[7:0]}} : req_wdata;
      end
    end
  end

  // Next-state logic: decode, ack/timeout tracking, response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (!mapped) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (!slot_is_led && dev_ack[slot]) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = read_val;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (slot_is_led ? led_ack : dev_ack[slot]) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = read_val;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign dev_sel   = (state_q == ST_ISSUE && mapped) ? (NUM_SLOTS'(1) << slot) : '0;
  assign dev_write = write_q;
  assign dev_byte  = byte_q;
  assign dev_addr  = addr_q[DEV_ADDR_W-1:0];
  assign dev_wdata = wdata_q;

endmodule
